// File: rtl/cla_share_arbiter.sv
// Round-robin front end that time-shares one external 8-bit CLA between two
// requesters, waits a fixed settle time, then returns a (optionally) saturated sum.
module cla_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          SAT_EN        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,

    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [8:0] add_sum,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_sum,
    output logic       rsp_ovf,
    output logic       rsp_uvf,

    output logic       busy,
    output logic [7:0] sat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       last_grant;
    logic       grant0;
    logic       grant1;
    logic       capture;

    logic       ovf_c;
    logic       uvf_c;
    logic [7:0] sum_c;
    logic       unused_carry;

    assign unused_carry = add_sum[8];

    // Grant is combinational in IDLE; rst_n gates it so readys are zero during reset.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n) begin
                    if (req0_valid && (!req1_valid || last_grant)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != ST_IDLE);
    assign capture    = (state == ST_WAIT) && (settle_cnt == '0);

    always_comb begin
        ovf_c = ~add_a[7] & ~add_b[7] &  add_sum[7];
        uvf_c =  add_a[7] &  add_b[7] & ~add_sum[7];
        sum_c = add_sum[7:0];
        if (SAT_EN && ovf_c) begin
            sum_c = 8'h7F;
        end else if (SAT_EN && uvf_c) begin
            sum_c = 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= '0;
            add_b      <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            settle_cnt <= '0;
        end else if (grant0 || grant1) begin
            add_a      <= grant1 ? req1_a : req0_a;
            add_b      <= grant1 ? req1_b : req0_b;
            rsp_id     <= grant1;
            last_grant <= grant1;
            settle_cnt <= SETTLE_LOAD;
        end else if (state == ST_WAIT && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_uvf   <= 1'b0;
            sat_cnt   <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_c;
            rsp_ovf   <= ovf_c;
            rsp_uvf   <= uvf_c;
            if ((ovf_c || uvf_c) && sat_cnt != '1) begin
                sat_cnt <= sat_cnt + 8'd1;
            end
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Scoreboard bench: two instances (settle 2 / saturating, settle 5 / raw) driven
// with directed and random traffic, checked against a signed-arithmetic model.
module tb_cla_share_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid [2];
    logic       req1_valid [2];
    logic       req0_ready [2];
    logic       req1_ready [2];
    logic [7:0] req0_a [2];
    logic [7:0] req0_b [2];
    logic [7:0] req1_a [2];
    logic [7:0] req1_b [2];
    logic [7:0] add_a [2];
    logic [7:0] add_b [2];
    logic [8:0] add_sum [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic       rsp_id [2];
    logic [7:0] rsp_sum [2];
    logic       rsp_ovf [2];
    logic       rsp_uvf [2];
    logic       busy [2];
    logic [7:0] sat_cnt [2];

    // External shared adder
    assign add_sum[0] = {1'b0, add_a[0]} + {1'b0, add_b[0]};
    assign add_sum[1] = {1'b0, add_a[1]} + {1'b0, add_b[1]};

    cla_share_arbiter #(.SETTLE_CYCLES(2), .SAT_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[0]), .req0_a(req0_a[0]), .req0_b(req0_b[0]), .req0_ready(req0_ready[0]),
        .req1_valid(req1_valid[0]), .req1_a(req1_a[0]), .req1_b(req1_b[0]), .req1_ready(req1_ready[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(add_sum[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_id(rsp_id[0]), .rsp_sum(rsp_sum[0]),
        .rsp_ovf(rsp_ovf[0]), .rsp_uvf(rsp_uvf[0]), .busy(busy[0]), .sat_cnt(sat_cnt[0])
    );

    cla_share_arbiter #(.SETTLE_CYCLES(5), .SAT_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid[1]), .req0_a(req0_a[1]), .req0_b(req0_b[1]), .req0_ready(req0_ready[1]),
        .req1_valid(req1_valid[1]), .req1_a(req1_a[1]), .req1_b(req1_b[1]), .req1_ready(req1_ready[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(add_sum[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_id(rsp_id[1]), .rsp_sum(rsp_sum[1]),
        .rsp_ovf(rsp_ovf[1]), .rsp_uvf(rsp_uvf[1]), .busy(busy[1]), .sat_cnt(sat_cnt[1])
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned timeouts = 0;
    bit          final_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  sum;
        bit          ovf;
        bit          uvf;
        int unsigned gcyc;
    } exp_t;

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit id, input logic [7:0] a, input logic [7:0] b,
                                   input bit sat, input int unsigned c);
        exp_t e;
        int   s;
        s      = int'($signed(a)) + int'($signed(b));
        e.id   = id;
        e.a    = a;
        e.b    = b;
        e.ovf  = (s > 127);
        e.uvf  = (s < -128);
        e.gcyc = c;
        if (sat && e.ovf)      e.sum = 8'h7F;
        else if (sat && e.uvf) e.sum = 8'h80;
        else                   e.sum = 8'(s);
        return e;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_chk
        localparam int unsigned S   = (d == 0) ? 2 : 5;
        localparam bit          SAT = (d == 0);

        exp_t        q[$];
        bit          last_m = 1'b1;
        int unsigned grants_m = 0;
        int unsigned rsps_m = 0;
        bit          seen = 1'b0;
        int unsigned sat_m = 0;

        // Issue side: predicts arbitration and pushes the expected response.
        always @(negedge clk) begin : issue
            int win;
            if (!rst_n) begin
                chk("ready_in_reset", d, 64'({req1_ready[d], req0_ready[d]}), 64'(0));
                last_m   <= 1'b1;
                grants_m <= 0;
            end else if (grants_m == rsps_m) begin
                win = -1;
                if (req0_valid[d] && req1_valid[d]) win = last_m ? 0 : 1;
                else if (req0_valid[d])             win = 0;
                else if (req1_valid[d])             win = 1;
                chk("grant", d, 64'({req1_ready[d], req0_ready[d]}),
                    64'((win == 1) ? 2 : (win == 0) ? 1 : 0));
                if (win == 0) q.push_back(model(1'b0, req0_a[d], req0_b[d], SAT, cyc));
                if (win == 1) q.push_back(model(1'b1, req1_a[d], req1_b[d], SAT, cyc));
                if (win >= 0) begin
                    last_m   <= (win == 1);
                    grants_m <= grants_m + 1;
                end
            end else begin
                chk("ready_while_busy", d, 64'({req1_ready[d], req0_ready[d]}), 64'(0));
            end
        end

        // Monitor side: compares whatever the DUT presents against the queue head.
        always @(negedge clk) begin : monitor
            if (!rst_n) begin
                chk("reset_outputs", d,
                    64'({rsp_valid[d], rsp_id[d], rsp_ovf[d], rsp_uvf[d], busy[d],
                         rsp_sum[d], sat_cnt[d], add_a[d], add_b[d]}), 64'(0));
                q.delete();
                rsps_m <= 0;
                seen   = 1'b0;
                sat_m  = 0;
            end else begin
                chk("busy", d, 64'(busy[d]), 64'(grants_m != rsps_m));
                if (grants_m != rsps_m && q.size() > 0)
                    chk("operands", d, 64'({add_a[d], add_b[d]}), 64'({q[0].a, q[0].b}));
                if (rsp_valid[d]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", d, 64'(rsp_valid[d]), 64'(0));
                    end else begin
                        if (!seen) begin
                            seen = 1'b1;
                            chk("latency", d, 64'(cyc - q[0].gcyc), 64'(S + 1));
                            if ((q[0].ovf || q[0].uvf) && sat_m < 255) sat_m++;
                        end
                        chk("rsp_id", d, 64'(rsp_id[d]), 64'(q[0].id));
                        chk("rsp_sum", d, 64'(rsp_sum[d]), 64'(q[0].sum));
                        chk("rsp_flags", d, 64'({rsp_ovf[d], rsp_uvf[d]}), 64'({q[0].ovf, q[0].uvf}));
                        if (rsp_ready[d]) begin
                            void'(q.pop_front());
                            rsps_m <= rsps_m + 1;
                            seen = 1'b0;
                        end
                    end
                end
                chk("sat_cnt", d, 64'(sat_cnt[d]), 64'(sat_m));
                if (final_chk) begin
                    chk("drained", d, 64'(q.size()), 64'(0));
                    chk("op_timeouts", d, 64'(timeouts), 64'(0));
                end
            end
        end
    end

    function automatic logic [7:0] pick();
        case ($urandom % 6)
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic op(input int d, input int id, input logic [7:0] a, input logic [7:0] b);
        bit got;
        @(posedge clk); #1;
        if (id == 0) begin req0_valid[d] = 1'b1; req0_a[d] = a; req0_b[d] = b; end
        else         begin req1_valid[d] = 1'b1; req1_a[d] = a; req1_b[d] = b; end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready[d] : req1_ready[d];
        end
        if (!got) timeouts++;
        @(posedge clk); #1;
        if (id == 0) req0_valid[d] = 1'b0;
        else         req1_valid[d] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req0_valid[d] = 1'b0; req1_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
            req0_a[d] = '0; req0_b[d] = '0; req1_a[d] = '0; req1_b[d] = '0;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;

        // Basic add and both saturation directions on each configuration
        for (int d = 0; d < 2; d++) begin
            op(d, 0, 8'h05, 8'h03);
            op(d, 1, 8'h70, 8'h20);
            op(d, 0, 8'h80, 8'hFF);
        end
        repeat (10) @(posedge clk);

        // Both requesters continuously valid
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                req0_valid[d] = 1'b1; req1_valid[d] = 1'b1;
                req0_a[d] = pick(); req0_b[d] = pick();
                req1_a[d] = pick(); req1_b[d] = pick();
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin req0_valid[d] = 1'b0; req1_valid[d] = 1'b0; end
        repeat (10) @(posedge clk);

        // Backpressure with a competing request waiting
        rsp_ready[0] = 1'b0;
        op(0, 0, 8'h11, 8'h22);
        req1_valid[0] = 1'b1; req1_a[0] = 8'h33; req1_b[0] = 8'h44;
        repeat (8) @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 req1_valid[0] = 1'b0;
        repeat (10) @(posedge clk);

        // Reset asserted while dut0 is settling
        op(0, 0, 8'h01, 8'h01);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(0, 1, 8'h02, 8'h02);
        repeat (10) @(posedge clk);

        // Random traffic with random backpressure
        repeat (600) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                req0_valid[d] = (($urandom % 3) == 0);
                req1_valid[d] = (($urandom % 3) == 0);
                req0_a[d] = pick(); req0_b[d] = pick();
                req1_a[d] = pick(); req1_b[d] = pick();
                rsp_ready[d] = (($urandom % 4) != 0);
            end
        end

        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            req0_valid[d] = 1'b0; req1_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1 final_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cla_share_arbiter.md
CLA_SHARE_ARBITER -- requirements
Module: cla_share_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: clock cycles the shared 8-bit CLA is given to settle before its sum is captured. Legal range 1..15.
REQ-002 Parameter SAT_EN, default 1: 1 = saturate the result on overflow/underflow; 0 = pass the raw 8-bit sum.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has an operand pair.
REQ-006 req0_a, req0_b  input  8 each  requester 0 two's-complement operands.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready  same as REQ-005..007, for requester 1.
REQ-009 add_a, add_b  output  8 each  registered operands driven to the shared cla_8bit.
REQ-010 add_sum  input  9  sum returned by the shared cla_8bit.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 rsp_id  output  1  requester that owns the result.
REQ-014 rsp_sum  output  8  result, saturated per SAT_EN.
REQ-015 rsp_ovf, rsp_uvf  output  1 each  overflow / underflow flags for the result.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 sat_cnt  output  8  count of results with ovf or uvf set; sticks at 0xFF.

Function
REQ-018 The FSM SHALL have three states:
- IDLE -> WAIT on a grant.
- WAIT -> RESP when the settle counter expires.
- RESP -> IDLE on rsp_valid & rsp_ready.
REQ-019 In IDLE, the block SHALL grant a requester whose valid is high and SHALL assert that requester's ready combinationally in the same cycle. The other ready SHALL stay low.
REQ-020 The grant handshake SHALL load add_a/add_b from the granted requester's operands, record rsp_id, and load the settle counter with SETTLE_CYCLES-1.
REQ-021 req0_ready and req1_ready SHALL be 0 in WAIT and RESP.
REQ-022 Arbitration SHALL be round-robin:
- If only one requester is valid, it wins.
- If both are valid, the requester not granted last wins.
- The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-023 add_a/add_b SHALL stay stable from the grant edge until the next grant.
REQ-024 The block SHALL stay in WAIT for exactly SETTLE_CYCLES cycles. On the final WAIT edge it SHALL capture add_sum, compute the response fields and enter RESP.
- Timing: a grant handshake in cycle T gives rsp_valid=1 in cycle T+SETTLE_CYCLES+1.
REQ-025 Flag computation, with a = add_a, b = add_b, s = captured add_sum:
- ovf = ~a[7] & ~b[7] & s[7]
- uvf = a[7] & b[7] & ~s[7]
REQ-026 Result selection:
- SAT_EN=1: rsp_sum = 0x7F if ovf, 0x80 if uvf, otherwise s[7:0].
- SAT_EN=0: rsp_sum = s[7:0].
- Flags SHALL be reported in both modes.
REQ-027 rsp_valid, rsp_id, rsp_sum and the flags SHALL hold stable throughout RESP until the rsp handshake. No new grant SHALL occur while a response is pending.
REQ-028 Response return:
- rsp_valid SHALL drop the cycle after the handshake.
- The earliest next grant SHALL be in that same IDLE cycle.
- Minimum throughput is one operation per SETTLE_CYCLES+2 cycles.
REQ-029 sat_cnt SHALL increment by 1 on the capture edge when ovf|uvf, saturating at 0xFF.
REQ-030 A requester dropping valid without a handshake SHALL have no effect. Operands SHALL be sampled only at the grant handshake.

Reset
REQ-031 While rst_n=0, independent of clk:
- state = IDLE, all outputs = 0.
- add_a = add_b = 0x00, last-grant pointer = 1, sat_cnt = 0.
REQ-032 A reset asserted in WAIT or RESP SHALL abort the operation. No response for it SHALL appear after reset releases.
REQ-033 The first grant SHALL be possible in the first clk edge after rst_n rises.

Verification
REQ-034 SETTLE_CYCLES=2, SAT_EN=1, req0 a=0x05 b=0x03, rsp_ready=1, handshake at T -> rsp_valid at T+3 with rsp_id=0, rsp_sum=0x08, ovf=0, uvf=0, then busy=0.
REQ-035 Saturation cases:
- req1 a=0x70 b=0x20 -> rsp_sum=0x7F, ovf=1, rsp_id=1.
- Then a=0x80 b=0xFF -> rsp_sum=0x80, uvf=1; sat_cnt=2.
- With SAT_EN=0, the same inputs give 0x90 and 0x7F, flags set.
REQ-036 Both requesters continuously valid from reset, 4 operations -> grant order 0,1,0,1, each rsp_id matching, readys never high together.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> response fields constant, req0_ready/req1_ready=0 throughout, grant one cycle after rsp_ready=1.
REQ-038 rst_n pulsed low in WAIT (req0 a=0x01 b=0x01) -> outputs zero immediately, no rsp_valid after release, next req1 a=0x02 b=0x02 returns 0x04 with id=1.
REQ-039 SETTLE_CYCLES=5 -> handshake-to-rsp_valid latency exactly 6 cycles.
